program_counter_ras: RTL and testbench

Parametrised program counter with a built-in return-address stack (RAS). Each cycle it selects the next PC from hold, sequential, absolute, PC-relative, call, or return sources, and pushes or pops return addresses on call and return. It sits at the head of the fetch stage, driven by the control unit's PC-select field, and adds stall, call, and return support to the basic four-way PC.

---
 rtl/program_counter_ras.sv | 102 ++++++++++
 tb/tb_program_counter_ras.sv | 122 ++++++++++++
 2 files changed

// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Next-PC selection is combinational; PC, stack and status flags are registered.
module program_counter_ras #(
  parameter int               WIDTH        = 64,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     PS,
  input  logic [WIDTH-1:0]               in,
  output logic [WIDTH-1:0]               PC,
  output logic [WIDTH-1:0]               PC4,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    PS_HOLD  = 3'b000,
    PS_SEQ   = 3'b001,
    PS_ABS   = 3'b010,
    PS_REL   = 3'b011,
    PS_CALL  = 3'b100,
    PS_RET   = 3'b101,
    PS_ICALL = 3'b110,
    PS_RSVD  = 3'b111
  } ps_e;

  logic [RAS_DEPTH-1:0][WIDTH-1:0] stack;
  logic [PW-1:0]                   tp;
  logic [PW-1:0]                   tp_inc, tp_dec;
  logic [WIDTH-1:0]                rel, pc_next;
  logic                            push, pop, empty, full, uflow_next;

  assign PC4    = PC + WIDTH'(4);
  // Shifting drops the top two bits of the offset, so negative offsets wrap.
  assign rel    = PC4 + {in[WIDTH-3:0], 2'b00};
  assign tp_inc = tp + PW'(1);
  assign tp_dec = tp - PW'(1);
  assign empty  = (ras_count == '0);
  assign full   = (ras_count == CW'(RAS_DEPTH));
  assign ras_top = empty ? '0 : stack[tp];

  always_comb begin
    pc_next    = PC;
    push       = 1'b0;
    pop        = 1'b0;
    uflow_next = 1'b0;
    case (ps_e'(PS))
      PS_HOLD:  pc_next = PC;
      PS_SEQ:   pc_next = PC4;
      PS_ABS:   pc_next = in;
      PS_REL:   pc_next = rel;
      PS_CALL:  begin pc_next = rel; push = 1'b1; end
      PS_RET: begin
        if (!empty) begin
          pc_next = ras_top;
          pop     = 1'b1;
        end else begin
          pc_next    = PC4;
          uflow_next = 1'b1;
        end
      end
      PS_ICALL: begin pc_next = in; push = 1'b1; end
      PS_RSVD:  pc_next = PC;
      default:  pc_next = PC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC            <= RESET_VECTOR;
      tp            <= '0;
      ras_count     <= '0;
      stack         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      if (!stall) begin
        PC            <= pc_next;
        ras_underflow <= uflow_next;
        if (push) begin
          // A full stack silently overwrites its oldest slot.
          stack[tp_inc] <= PC4;
          tp            <= tp_inc;
          if (full) ras_overflow <= 1'b1;
          else      ras_count    <= ras_count + CW'(1);
        end else if (pop) begin
          tp        <= tp_dec;
          ras_count <= ras_count - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_program_counter_ras.sv
// Directed test of program_counter_ras: sequencing, branches, call/return
// nesting, overflow, underflow, stall and reset override.
module tb_program_counter_ras;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 64'h100;

  logic             clock = 1'b0;
  logic             reset, stall;
  logic [2:0]       PS;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] PC, PC4, ras_top;
  logic [2:0]       ras_count;
  logic             ras_overflow, ras_underflow;

  int n_chk = 0;
  int n_fail = 0;

  program_counter_ras #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .stall(stall), .PS(PS), .in(in),
    .PC(PC), .PC4(PC4), .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, then sample just after the edge.
  task automatic cyc(input logic [2:0] ps, input logic [WIDTH-1:0] val);
    PS = ps;
    in = val;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [WIDTH-1:0] pc,
                           input logic [WIDTH-1:0] top, input logic [2:0] cnt,
                           input logic ov, input logic uf);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".pc4"}, PC4, pc + 64'd4);
    chk({tag, ".top"}, ras_top, top);
    chk({tag, ".cnt"}, {61'd0, ras_count}, {61'd0, cnt});
    chk({tag, ".ov"}, {63'd0, ras_overflow}, {63'd0, ov});
    chk({tag, ".uf"}, {63'd0, ras_underflow}, {63'd0, uf});
  endtask

  logic [WIDTH-1:0] ret_addr [5];
  logic [WIDTH-1:0] tgt;

  initial begin
    reset = 1'b1; stall = 1'b0; PS = 3'b000; in = '0;
    cyc(3'b000, '0);
    cyc(3'b000, '0);
    chk_state("reset", 64'h100, 64'h0, 3'd0, 1'b0, 1'b0);

    // Sequential fetch
    reset = 1'b0;
    cyc(3'b001, '0); chk_state("seq1", 64'h104, 64'h0, 3'd0, 1'b0, 1'b0);
    cyc(3'b001, '0); chk_state("seq2", 64'h108, 64'h0, 3'd0, 1'b0, 1'b0);
    cyc(3'b001, '0); chk_state("seq3", 64'h10C, 64'h0, 3'd0, 1'b0, 1'b0);

    // Absolute and relative branches
    cyc(3'b010, 64'h200);             chk("abs", PC, 64'h200);
    cyc(3'b011, 64'hFFFF_FFFF_FFFF_FFFC); chk("rel_neg", PC, 64'h1F4);
    cyc(3'b010, 64'h200);
    cyc(3'b011, 64'd3);               chk("rel_pos", PC, 64'h210);
    cyc(3'b000, 64'h555);             chk("hold", PC, 64'h210);
    cyc(3'b111, 64'h555);             chk_state("rsvd", 64'h210, 64'h0, 3'd0, 1'b0, 1'b0);

    // Call/return nesting, including return right after a call
    cyc(3'b010, 64'h40);
    cyc(3'b100, 64'h10);  chk_state("call", 64'h84, 64'h44, 3'd1, 1'b0, 1'b0);
    cyc(3'b110, 64'h900); chk_state("icall", 64'h900, 64'h88, 3'd2, 1'b0, 1'b0);
    cyc(3'b101, '0);      chk_state("ret1", 64'h88, 64'h44, 3'd1, 1'b0, 1'b0);
    cyc(3'b101, '0);      chk_state("ret2", 64'h44, 64'h0, 3'd0, 1'b0, 1'b0);

    // Five indirect calls into a four-deep stack
    ret_addr[0] = 64'h48;
    for (int k = 1; k <= 5; k++) begin
      tgt = 64'h1000 * k;
      cyc(3'b110, tgt);
      if (k < 5) ret_addr[k] = tgt + 64'd4;
      chk_state($sformatf("ovcall%0d", k), tgt, (k == 1) ? 64'h48 : ret_addr[k-1],
                (k < 4) ? 3'(k) : 3'd4, (k == 5), 1'b0);
    end
    for (int k = 4; k >= 1; k--) begin
      cyc(3'b101, '0);
      chk_state($sformatf("ovret%0d", k), ret_addr[k], (k > 1) ? ret_addr[k-1] : 64'h0,
                3'(k - 1), 1'b0, 1'b0);
    end

    // Underflow: empty stack return falls through
    cyc(3'b010, 64'h300);
    cyc(3'b101, '0); chk_state("uflow", 64'h304, 64'h0, 3'd0, 1'b0, 1'b1);
    cyc(3'b001, '0); chk_state("uflow_clr", 64'h308, 64'h0, 3'd0, 1'b0, 1'b0);

    // Stall freezes PC and stack
    cyc(3'b100, '0); chk_state("pre_stall", 64'h30C, 64'h30C, 3'd1, 1'b0, 1'b0);
    stall = 1'b1;
    cyc(3'b100, 64'h10); chk_state("stall_call", 64'h30C, 64'h30C, 3'd1, 1'b0, 1'b0);
    cyc(3'b101, '0);     chk_state("stall_ret", 64'h30C, 64'h30C, 3'd1, 1'b0, 1'b0);
    stall = 1'b0;

    // Reset overrides a pending return
    cyc(3'b100, '0);
    cyc(3'b100, '0); chk_state("pre_rst", 64'h314, 64'h314, 3'd3, 1'b0, 1'b0);
    reset = 1'b1; stall = 1'b1;
    cyc(3'b101, '0); chk_state("rst_mid", 64'h100, 64'h0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0; stall = 1'b0;
    cyc(3'b001, '0); chk_state("post_rst", 64'h104, 64'h0, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
